response_reorder_buffer: RTL

//  Sits between the memory response channel and pattern_decoder's push/push_tag/data inputs.

---
 rtl/response_reorder_buffer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/response_reorder_buffer.sv
// response_reorder_buffer
//  Tracks read tags issued by the decoder and buffers memory responses that
//  come back out of order. Responses are replayed to the decoder strictly in
//  issue order, at most one per cycle. The decoder is held off through
//  req_stall while the next slot in issue order is still in use.
//  Optional feature macro: REORDER_BYPASS_EN. When it is defined, a response
//  for the head tag is emitted on the next cycle and never stored.
module response_reorder_buffer #(
  parameter  int DATA_WIDTH = 64,
  parameter  int TAG_COUNT  = 4,
  localparam int TAG_WIDTH  = $clog2(TAG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  req_stall,
  input  logic                  mem_push,
  input  logic [TAG_WIDTH-1:0]  mem_push_tag,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  push,
  output logic [TAG_WIDTH-1:0]  push_tag,
  output logic [DATA_WIDTH-1:0] data,
  output logic [TAG_WIDTH:0]    outstanding,
  output logic                  err
);

  localparam logic [TAG_WIDTH-1:0] TAG_ONE = {{(TAG_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TAG_WIDTH:0]   CNT_ONE = {{TAG_WIDTH{1'b0}}, 1'b1};

  // Slot bookkeeping: pending = tag issued and not yet emitted,
  // full = response data held in the slot.
  logic [TAG_COUNT-1:0]  pending_q, pending_d;
  logic [TAG_COUNT-1:0]  full_q, full_d;
  logic [DATA_WIDTH-1:0] slot_data_q [TAG_COUNT];
  logic [DATA_WIDTH-1:0] slot_data_d [TAG_COUNT];
  logic [TAG_WIDTH-1:0]  iss_ptr_q, iss_ptr_d;
  logic [TAG_WIDTH-1:0]  head_q, head_d;
  logic [TAG_WIDTH:0]    outstanding_q, outstanding_d;
  logic                  err_q, err_d;
  logic                  push_q, push_d;
  logic [TAG_WIDTH-1:0]  push_tag_q, push_tag_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic accept_s;
  logic drain_s;
  logic bypass_s;
  logic resp_ok_s;
  logic emit_s;

  // A slot can only be reused once its previous tag has been emitted.
  assign req_stall = pending_q[iss_ptr_q];
  assign accept_s  = req & ~pending_q[iss_ptr_q];
  assign drain_s   = full_q[head_q];
  // A response is legal only for an issued tag whose slot is still empty.
  assign resp_ok_s = mem_push & pending_q[mem_push_tag] & ~full_q[mem_push_tag];

`ifdef REORDER_BYPASS_EN
  // The head response skips the slot, unless stored head data is already leaving.
  assign bypass_s = resp_ok_s & (mem_push_tag == head_q) & ~full_q[head_q];
`else
  assign bypass_s = 1'b0;
`endif

  assign emit_s = drain_s | bypass_s;

  assign push        = push_q;
  assign push_tag    = push_tag_q;
  assign data        = data_q;
  assign outstanding = outstanding_q;
  assign err         = err_q;

  // Next-state logic: drain/bypass emit, response capture, issue tracking, counters.
  always_comb begin
    pending_d     = pending_q;
    full_d        = full_q;
    slot_data_d   = slot_data_q;
    iss_ptr_d     = iss_ptr_q;
    head_d        = head_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
    push_d        = 1'b0;
    push_tag_d    = push_tag_q;
    data_d        = data_q;

    // Emit: stored head data has priority. Bypass cannot coincide with it.
    if (drain_s) begin
      push_d           = 1'b1;
      push_tag_d       = head_q;
      data_d           = slot_data_q[head_q];
      pending_d[head_q] = 1'b0;
      full_d[head_q]    = 1'b0;
      head_d           = head_q + TAG_ONE;
    end else if (bypass_s) begin
      push_d           = 1'b1;
      push_tag_d       = head_q;
      data_d           = mem_data;
      pending_d[head_q] = 1'b0;
      head_d           = head_q + TAG_ONE;
    end else begin
      push_d = 1'b0;
    end

    // Response capture. Illegal responses are dropped and flagged.
    if (mem_push) begin
      if (resp_ok_s) begin
        if (!bypass_s) begin
          slot_data_d[mem_push_tag] = mem_data;
          full_d[mem_push_tag]      = 1'b1;
        end else begin
          full_d[mem_push_tag] = full_q[mem_push_tag];
        end
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = err_d;
    end

    // Issue: the slot at iss_ptr is allocated even when the tag is wrong.
    // The accepted slot is never pending, so it cannot be the head being emitted.
    if (accept_s) begin
      pending_d[iss_ptr_q] = 1'b1;
      iss_ptr_d            = iss_ptr_q + TAG_ONE;
      if (req_tag != iss_ptr_q) begin
        err_d = 1'b1;
      end else begin
        err_d = err_d;
      end
    end else begin
      iss_ptr_d = iss_ptr_q;
    end

    case ({accept_s, emit_s})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE;
      2'b01:   outstanding_d = outstanding_q - CNT_ONE;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State register with synchronous reset. Reset discards all buffered data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= '0;
      full_q        <= '0;
      iss_ptr_q     <= '0;
      head_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      push_q        <= 1'b0;
      push_tag_q    <= '0;
      data_q        <= '0;
      for (int i = 0; i < TAG_COUNT; i++) begin
        slot_data_q[i] <= '0;
      end
    end else begin
      pending_q     <= pending_d;
      full_q        <= full_d;
      iss_ptr_q     <= iss_ptr_d;
      head_q        <= head_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      push_q        <= push_d;
      push_tag_q    <= push_tag_d;
      data_q        <= data_d;
      slot_data_q   <= slot_data_d;
    end
  end

endmodule
